// File: rtl/xor_parity_checker_pkg.sv
// Shared definitions for the XOR parity link: FSM encoding, parity-mode constants and the
// parity verdict helper, so transmitter and checker agree on the same values.
package xor_parity_checker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StData   = 2'd1;
  localparam state_t StParity = 2'd2;
  localparam state_t StHold   = 2'd3;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // odd selects the required XOR of all data bits plus the parity bit.
  function automatic logic parity_ok(input logic xor_bit, input logic p, input logic odd);
    return ((xor_bit ^ p) == odd);
  endfunction

endpackage

// File: rtl/xor_parity_checker_if.sv
// Serial beat input and byte result output of the XOR parity checker.
// master = link front end / consumer side, slave = checker side.
interface xor_parity_checker_if #(
  parameter int unsigned DATA_W = 8
);

  logic              in_valid;
  logic              in_sof;
  logic              in_bit;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_parity_ok;

  modport master (
    output in_valid,
    output in_sof,
    output in_bit,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_parity_ok
  );

  modport slave (
    input  in_valid,
    input  in_sof,
    input  in_bit,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_parity_ok
  );

endinterface

// File: rtl/xor_parity_checker_xor_shift_acc.sv
// MSB-first shift register with a running XOR of every bit shifted in.
// load starts a new frame with din; shift appends din at the LSB.
module xor_shift_acc #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic              din,
  output logic [DATA_W-1:0] data,
  output logic              xor_bit
);

  logic [DATA_W-1:0] data_q;
  logic              xor_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      xor_q  <= 1'b0;
    end else if (load) begin
      data_q <= DATA_W'(din);
      xor_q  <= din;
    end else if (shift) begin
      data_q <= (data_q << 1) | DATA_W'(din);
      xor_q  <= xor_q ^ din;
    end
  end

  assign data    = data_q;
  assign xor_bit = xor_q;

endmodule

// File: rtl/xor_parity_checker.sv
// Receive side of the XOR parity link: deserialises start-marked frames, checks the trailing
// parity bit, presents the byte on valid/ready and keeps a saturating parity-error count.
module xor_parity_checker #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  xor_parity_checker_if.slave  bus,
  output logic [ERR_W-1:0]     err_count
);

  import xor_parity_checker_pkg::state_t;
  import xor_parity_checker_pkg::StIdle;
  import xor_parity_checker_pkg::StData;
  import xor_parity_checker_pkg::StParity;
  import xor_parity_checker_pkg::StHold;
  import xor_parity_checker_pkg::parity_ok;

  localparam logic OddMode = (PARITY_ODD != 0) ? xor_parity_checker_pkg::PARITY_ODD
                                               : xor_parity_checker_pkg::PARITY_EVEN;
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W);
  localparam state_t FirstState = (DATA_W == 1) ? StParity : StData;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              ok_q, ok_d;

  logic              beat;
  logic              sof_beat;
  logic              acc_shift;
  logic              parity_match;
  logic [DATA_W-1:0] acc_data;
  logic              acc_xor;

  assign bus.in_ready = (state_q != StHold);
  assign beat         = bus.in_valid & bus.in_ready;
  assign sof_beat     = beat & bus.in_sof;
  // In PARITY the beat carries the parity bit, so it must not enter the shift register.
  assign acc_shift    = beat & ~bus.in_sof & (state_q == StData);
  assign parity_match = parity_ok(acc_xor, bus.in_bit, OddMode);

  xor_shift_acc #(
    .DATA_W (DATA_W)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .load    (sof_beat),
    .shift   (acc_shift),
    .din     (bus.in_bit),
    .data    (acc_data),
    .xor_bit (acc_xor)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ok_d        = ok_q;

    case (state_q)
      StIdle: begin
        if (sof_beat) begin
          cnt_d   = CntW'(1);
          state_d = FirstState;
        end
      end
      StData: begin
        if (sof_beat) begin
          cnt_d   = CntW'(1);
          state_d = FirstState;
        end else if (beat) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntLast) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (sof_beat) begin
          cnt_d   = CntW'(1);
          state_d = FirstState;
        end else if (beat) begin
          out_data_d  = acc_data;
          ok_d        = parity_match;
          out_valid_d = 1'b1;
          state_d     = StHold;
          if (!parity_match && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
          end
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ok_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ok_q        <= ok_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_parity_ok = ok_q;
  assign err_count         = err_q;

endmodule

// File: tb/tb_xor_parity_checker.sv
// Drives an even-parity and an odd-parity checker with the same beats; a scoreboard of
// expected results per checker is compared whenever a result is handed over.
module tb_xor_parity_checker;

  typedef struct packed {
    logic [7:0] data;
    logic       ok;
    logic [7:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] err_even;
  logic [7:0] err_odd;

  exp_t       q_even[$];
  exp_t       q_odd[$];
  exp_t       e_even;
  exp_t       e_odd;
  logic [7:0] err_m_even = 8'd0;
  logic [7:0] err_m_odd  = 8'd0;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  xor_parity_checker_if #(.DATA_W(8)) ife ();
  xor_parity_checker_if #(.DATA_W(8)) ifo ();

  assign ifo.in_valid  = ife.in_valid;
  assign ifo.in_sof    = ife.in_sof;
  assign ifo.in_bit    = ife.in_bit;
  assign ifo.out_ready = ife.out_ready;

  xor_parity_checker #(
    .DATA_W     (8),
    .PARITY_ODD (0),
    .ERR_W      (8)
  ) dut_even (
    .clk       (clk),
    .reset     (reset),
    .bus       (ife.slave),
    .err_count (err_even)
  );

  xor_parity_checker #(
    .DATA_W     (8),
    .PARITY_ODD (1),
    .ERR_W      (8)
  ) dut_odd (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifo.slave),
    .err_count (err_odd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
    end
  endtask

  // Reference model: even checker wants XOR(data,p)==0, odd checker wants 1.
  task automatic expect_frame(input logic [7:0] d, input logic p);
    logic ok_e;
    ok_e = ((^d ^ p) == 1'b0);
    if (!ok_e && err_m_even != 8'hFF) err_m_even = err_m_even + 8'd1;
    if (ok_e && err_m_odd != 8'hFF) err_m_odd = err_m_odd + 8'd1;
    q_even.push_back('{data: d, ok: ok_e, err: err_m_even});
    q_odd.push_back('{data: d, ok: !ok_e, err: err_m_odd});
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && ife.out_valid === 1'b1 && ife.out_ready === 1'b1) begin
      check("even_pending", 32'(q_even.size() > 0), 32'd1);
      if (q_even.size() > 0) begin
        e_even = q_even.pop_front();
        check("even_data", 32'(ife.out_data), 32'(e_even.data));
        check("even_ok", 32'(ife.out_parity_ok), 32'(e_even.ok));
        check("even_err", 32'(err_even), 32'(e_even.err));
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && ifo.out_valid === 1'b1 && ifo.out_ready === 1'b1) begin
      check("odd_pending", 32'(q_odd.size() > 0), 32'd1);
      if (q_odd.size() > 0) begin
        e_odd = q_odd.pop_front();
        check("odd_data", 32'(ifo.out_data), 32'(e_odd.data));
        check("odd_ok", 32'(ifo.out_parity_ok), 32'(e_odd.ok));
        check("odd_err", 32'(err_odd), 32'(e_odd.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int gap_after = -1,
                            input int gap_len = 0);
    for (int i = 0; i < 8; i++) begin
      ife.in_valid = 1'b1;
      ife.in_sof   = (i == 0);
      ife.in_bit   = d[7-i];
      step();
      if (i == gap_after) begin
        ife.in_valid = 1'b0;
        repeat (gap_len) step();
      end
    end
    ife.in_valid = 1'b1;
    ife.in_sof   = 1'b0;
    ife.in_bit   = p;
    expect_frame(d, p);
    step();
    ife.in_valid = 1'b0;
    @(negedge clk);
    check("latency_even_valid", 32'(ife.out_valid), 32'd1);
    check("latency_odd_valid", 32'(ifo.out_valid), 32'd1);
    step();
  endtask

  task automatic drive_bits(input int n, input logic first_sof, input logic b);
    for (int i = 0; i < n; i++) begin
      ife.in_valid = 1'b1;
      ife.in_sof   = first_sof && (i == 0);
      ife.in_bit   = b;
      step();
    end
    ife.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    reset         = 1'b1;
    ife.in_valid  = 1'b0;
    ife.in_sof    = 1'b0;
    ife.in_bit    = 1'b0;
    ife.out_ready = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(ife.in_ready), 32'd1);
    check("rst_out_valid", 32'(ife.out_valid), 32'd0);
    check("rst_out_data", 32'(ife.out_data), 32'd0);
    check("rst_parity_ok", 32'(ife.out_parity_ok), 32'd0);
    check("rst_err_even", 32'(err_even), 32'd0);
    check("rst_err_odd", 32'(err_odd), 32'd0);
    check("rst_odd_valid", 32'(ifo.out_valid), 32'd0);
    step();

    // Clean frame, then a parity error.
    send_frame(8'h05, 1'b0);
    send_frame(8'h06, 1'b1);
    check("err_after_bad", 32'(err_even), 32'd1);

    // Input stall of 3 cycles between bits 4 and 5.
    send_frame(8'hA5, 1'b0, 3, 3);

    // Backpressure: result must stay put and HOLD must refuse beats.
    ife.out_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ife.in_valid = 1'b1;
      ife.in_sof   = 1'b1;
      ife.in_bit   = 1'b1;
      @(negedge clk);
      check("hold_valid", 32'(ife.out_valid), 32'd1);
      check("hold_data", 32'(ife.out_data), 32'h3C);
      check("hold_ok", 32'(ife.out_parity_ok), 32'd1);
      check("hold_in_ready", 32'(ife.in_ready), 32'd0);
      step();
    end
    ife.in_valid  = 1'b0;
    ife.out_ready = 1'b1;
    step();
    step();

    // Beats without sof in IDLE are dropped; a second sof restarts a partial frame.
    drive_bits(6, 1'b0, 1'b1);
    @(negedge clk);
    check("idle_no_output", 32'(ife.out_valid), 32'd0);
    step();
    drive_bits(4, 1'b1, 1'b1);
    send_frame(8'h03, 1'b0);
    check("restart_err_even", 32'(err_even), 32'(err_m_even));

    // 300 bad frames for the even checker: counter must saturate.
    for (int i = 0; i < 300; i++) begin
      d = 8'(i * 37 + 11);
      send_frame(d, ~(^d));
    end
    check("err_saturated", 32'(err_even), 32'hFF);

    // Reset mid-frame discards it and clears the counters.
    drive_bits(5, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    err_m_even = 8'd0;
    err_m_odd  = 8'd0;
    @(negedge clk);
    check("midrst_valid", 32'(ife.out_valid), 32'd0);
    check("midrst_err_even", 32'(err_even), 32'd0);
    check("midrst_err_odd", 32'(err_odd), 32'd0);
    check("midrst_in_ready", 32'(ife.in_ready), 32'd1);
    step();
    send_frame(8'hFF, 1'b0);
    send_frame(8'h05, 1'b1);
    send_frame(8'h05, 1'b0);
    check("final_err_odd", 32'(err_odd), 32'd2);

    repeat (3) step();
    check("even_queue_drained", 32'(q_even.size()), 32'd0);
    check("odd_queue_drained", 32'(q_odd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_parity_checker.md
Name: xor_parity_checker

Overview:
- Receive end of the team's XOR parity link: serial frame in, byte plus parity verdict out.
- Frame = start marker, DATA_W data bits MSB-first, one parity bit, all sampled on in_valid.
- Recomputes the running XOR of the data bits, compares it against the received parity bit, and presents the byte on a valid/ready output.
- Sits between the serial link front end and byte-wide consumer logic; keeps a saturating count of parity failures.

Parameters:
- DATA_W, 8, data bits per frame (2..32).
- PARITY_ODD, 0, 0 = even parity expected (XOR of data and parity bit == 0); 1 = odd.
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit/in_sof qualify this cycle.
- in_sof  input  1  start of frame; the bit on in_bit in the same beat is the first (MSB) data bit.
- in_bit  input  1  serial data or parity bit.
- in_ready  output  1  checker accepts a beat this cycle.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  DATA_W  received byte, bit DATA_W-1 = first bit received.
- out_parity_ok  output  1  1 = parity matched.
- err_count  output  ERR_W  saturating count of frames with parity mismatch.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, on reset sampled high at a clk rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_parity_ok=0, err_count=0, bit counter=0, running XOR=0.
- Beat: a beat is accepted when in_valid & in_ready. in_ready = 1 in IDLE/DATA/PARITY and 0 in HOLD.
- IDLE: accepted beats without in_sof are dropped. A beat with in_sof loads the shift register with in_bit, sets xor=in_bit and cnt=1, then goes to DATA (or to PARITY if DATA_W==1).
- DATA:
  - Each accepted beat shifts in_bit in at the LSB, sets xor ^= in_bit and cnt += 1.
  - When cnt reaches DATA_W, go to PARITY.
  - in_sof on an accepted beat restarts the frame: the partial frame is discarded, the beat is treated as IDLE+sof, and err_count is unchanged.
- PARITY:
  - The accepted beat is the parity bit p. Set ok = ((xor ^ p) == PARITY_ODD).
  - Register out_data and out_parity_ok, set out_valid=1, go to HOLD.
  - If !ok, err_count increments and saturates at all-ones.
  - in_sof on the parity beat: restart exactly as in DATA; no result is produced.
- HOLD: out_valid=1, outputs stable. On out_ready, out_valid drops next cycle and the state returns to IDLE. Inputs are ignored (in_ready=0).
- Latency: the parity beat is accepted at edge N, and out_valid is high after edge N (visible in cycle N+1).
- Throughput: one frame per DATA_W+1 accepted beats, plus at least 1 cycle in HOLD.
- Stall: in_valid low holds all state; there is no timeout.
- Reset mid-frame or while in HOLD: the frame is discarded, out_valid drops, and err_count clears.
- out_ready is ignored when out_valid=0.

Decomposition:
- Shared package: state encoding (IDLE, DATA, PARITY, HOLD) and the constants PARITY_EVEN=0 / PARITY_ODD=1, so the matching transmitter uses identical values.
- One natural sub-module: xor_shift_acc.
  - DATA_W shift register plus running-XOR bit, with load/shift enables.
  - The FSM, counter and error counter stay in the top level.

Test Plan:
- Clean frame, even parity: sof + bits 00000101, parity 0 -> out_valid one cycle after the parity beat, out_data=0x05, out_parity_ok=1, err_count=0.
- Parity error: bits 00000110, parity 1 (even mode) -> out_data=0x06, out_parity_ok=0, err_count=1. Repeat 300 frames with ERR_W=8 -> err_count saturates at 255.
- Stall and backpressure:
  - Frame 0xA5 with in_valid low 3 cycles between bits 4 and 5 -> same result 0xA5, parity_ok=1.
  - Hold out_ready=0 for 5 cycles -> out_valid stays 1, outputs unchanged, in_ready=0, beats offered in HOLD are not consumed.
- Restart: sof + 4 bits of 1111, then sof + 00000011, parity 0 -> single result 0x03 ok, err_count unchanged; IDLE beats without sof produce nothing.
- Reset mid-frame: assert reset after 5 bits -> next cycle out_valid=0, err_count=0; next full frame 0xFF parity 0 -> 0xFF, ok=1.
- Odd mode (PARITY_ODD=1): bits 00000101, parity 1 -> ok=1; parity 0 -> ok=0, err_count=1.
